// File: rtl/double_pkg.sv
// Shared double-precision constants and helpers for the compare arbiter and its clients.
// Latency: none, declarations only.
// Backpressure: not applicable.
package double_pkg;

    localparam int DW = 64;

    localparam logic [DW-1:0] ONE     = 64'h3FF0000000000000;
    localparam logic [DW-1:0] TWO     = 64'h4000000000000000;
    localparam logic [DW-1:0] NEG_ONE = 64'hBFF0000000000000;
    localparam logic [DW-1:0] QNAN    = 64'h7FF8000000000000;

    // Ceiling log2, used to size requester ids; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/double_lt_arbiter_rr_pick.sv
// N-way round-robin picker: one-hot grant to the first requester after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no request is present.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // The last-served requester is visited last, giving it lowest priority.
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/double_lt_arbiter.sv
// Shares one pipelined double a<b comparator between N requesters, round-robin, one issue per cycle.
// Latency: handshake in cycle t returns a one-hot tagged response in cycle t+1+LT_LATENCY.
// Backpressure: valid/ready on requests; responses cannot be stalled and must be taken when they fire.
module double_lt_arbiter
    import double_pkg::*;
#(
    parameter int N          = 4,
    parameter int LT_LATENCY = 1,
    parameter int IDW        = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [DW*N-1:0] req_a,
    input  logic [DW*N-1:0] req_b,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic            resp_z,
    output logic [DW-1:0]   lt_a,
    output logic [DW-1:0]   lt_b,
    input  logic            lt_z,
    output logic            busy
);

    localparam int DEPTH = LT_LATENCY + 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic           hs;
    logic [DW-1:0]  a_arr [N];
    logic [DW-1:0]  b_arr [N];
    tag_t           tag_pipe [DEPTH];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DW +: DW];
        assign b_arr[i] = req_b[i*DW +: DW];
    end

    rr_pick #(
        .N  (N),
        .IW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (req_ready),
        .idx (gnt_idx)
    );

    // The picker only grants a valid requester, so any grant bit is a handshake.
    assign hs = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDW'(N - 1);
            lt_a   <= '0;
            lt_b   <= '0;
        end else if (hs) begin
            rr_ptr <= gnt_idx;
            lt_a   <= a_arr[gnt_idx];
            lt_b   <= b_arr[gnt_idx];
        end
    end

    // Tag pipe mirrors the comparator depth; it never stalls, so tags and lt_z stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{vld: hs, id: gnt_idx};
            for (int i = 1; i < DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_z     = 1'b0;
        if (tag_pipe[DEPTH-1].vld) begin
            resp_valid[tag_pipe[DEPTH-1].id] = 1'b1;
            resp_z                           = lt_z;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | tag_pipe[i].vld;
        end
    end

endmodule

// File: tb/tb_double_lt_arbiter.sv
// Bench for double_lt_arbiter: table vectors, hand sequences and random traffic against a queue model.
// Latency: the external comparator is modelled with LT_LATENCY register stages.
// Backpressure: requesters hold operands until granted; responses are always accepted.
module tb_double_lt_arbiter;
    import double_pkg::*;

    localparam int N   = 4;
    localparam int L   = 1;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [DW*N-1:0] req_a;
    logic [DW*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic            resp_z;
    logic [DW-1:0]   lt_a;
    logic [DW-1:0]   lt_b;
    logic            lt_z;
    logic            busy;

    logic [DW-1:0]   op_a [N];
    logic [DW-1:0]   op_b [N];

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
        end
    end

    // External comparator: free-running, not reset, so it keeps producing lt_z for dropped work.
    bit zp [L];
    always_ff @(posedge clk) begin
        zp[0] <= ($bitstoreal(lt_a) < $bitstoreal(lt_b));
        for (int i = 1; i < L; i++) zp[i] <= zp[i-1];
    end
    assign lt_z = zp[L-1];

    double_lt_arbiter #(
        .N          (N),
        .LT_LATENCY (L),
        .IDW        (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_z     (resp_z),
        .lt_a       (lt_a),
        .lt_b       (lt_b),
        .lt_z       (lt_z),
        .busy       (busy)
    );

    typedef struct {
        int due;
        int id;
        bit z;
    } pend_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] rdy;
    } vec_t;

    pend_t        pend[$];
    vec_t         tbl[$];
    int           cyc;
    int           last;
    int           exp_idx;
    logic [DW-1:0] exp_lta;
    logic [DW-1:0] exp_ltb;
    logic [N-1:0] prev_gnt;
    int           checks;
    int           errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next requester after the last served one, wrapping; -1 when nobody asks.
    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic model_check();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic         ez;
        exp_idx = pick(req_valid, last);
        exp_rdy = '0;
        if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
        exp_rv = '0;
        ez     = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv[pend[0].id] = 1'b1;
            ez                 = pend[0].z;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("resp_z", 64'(resp_z), 64'(ez));
        chk("busy", 64'(busy), 64'(pend.size() > 0));
        chk("lt_a", lt_a, exp_lta);
        chk("lt_b", lt_b, exp_ltb);
        if (resp_valid != '0) chk("resp_z_passthru", 64'(resp_z), 64'(lt_z));
    endtask

    task automatic advance();
        @(posedge clk);
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        prev_gnt = '0;
        if (exp_idx >= 0) begin
            pend.push_back('{due: cyc + 1 + L, id: exp_idx,
                             z: ($bitstoreal(op_a[exp_idx]) < $bitstoreal(op_b[exp_idx]))});
            last              = exp_idx;
            exp_lta           = op_a[exp_idx];
            exp_ltb           = op_b[exp_idx];
            prev_gnt[exp_idx] = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        settle();
        model_check();
        advance();
    endtask

    task automatic reset_cycle();
        rst_n     = 1'b0;
        req_valid = '0;
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_lt_a", lt_a, 64'd0);
        chk("rst_lt_b", lt_b, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend.delete();
        last     = N - 1;
        exp_lta  = '0;
        exp_ltb  = '0;
        prev_gnt = '0;
        cyc++;
    endtask

    function automatic logic [63:0] rand_dbl();
        case ($urandom_range(0, 6))
            0:       return ONE;
            1:       return TWO;
            2:       return NEG_ONE;
            3:       return QNAN;
            4:       return 64'h0;
            5:       return 64'h8000000000000000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_fixed_ops();
        op_a[0] = ONE;     op_b[0] = TWO;
        op_a[1] = TWO;     op_b[1] = ONE;
        op_a[2] = NEG_ONE; op_b[2] = ONE;
        op_a[3] = QNAN;    op_b[3] = ONE;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_cycle();

        // Single request: grant in cycle 0, lt_a in cycle 1, response in cycle 2.
        set_fixed_ops();
        req_valid = 4'b0001;
        settle(); model_check();
        chk("single_rdy", 64'(req_ready), 64'h1);
        advance();
        req_valid = '0;
        settle(); model_check();
        chk("single_lt_a", lt_a, ONE);
        chk("single_busy1", 64'(busy), 64'd1);
        advance();
        settle(); model_check();
        chk("single_resp_valid", 64'(resp_valid), 64'h1);
        chk("single_resp_z", 64'(resp_z), 64'd1);
        chk("single_busy2", 64'(busy), 64'd1);
        advance();
        settle(); model_check();
        chk("single_busy3", 64'(busy), 64'd0);
        advance();

        // Round robin, pointer wrap, back-to-back and NaN passthrough vectors.
        reset_cycle();
        tbl.push_back('{v: 4'b1111, rdy: 4'b0001});
        tbl.push_back('{v: 4'b1111, rdy: 4'b0010});
        tbl.push_back('{v: 4'b1111, rdy: 4'b0100});
        tbl.push_back('{v: 4'b1111, rdy: 4'b1000});
        tbl.push_back('{v: 4'b1111, rdy: 4'b0001});
        tbl.push_back('{v: 4'b0100, rdy: 4'b0100});
        tbl.push_back('{v: 4'b1010, rdy: 4'b1000});
        tbl.push_back('{v: 4'b1010, rdy: 4'b0010});
        tbl.push_back('{v: 4'b0100, rdy: 4'b0100});
        tbl.push_back('{v: 4'b0100, rdy: 4'b0100});
        tbl.push_back('{v: 4'b0100, rdy: 4'b0100});
        tbl.push_back('{v: 4'b0000, rdy: 4'b0000});
        tbl.push_back('{v: 4'b0000, rdy: 4'b0000});
        tbl.push_back('{v: 4'b1000, rdy: 4'b1000});
        tbl.push_back('{v: 4'b0000, rdy: 4'b0000});
        tbl.push_back('{v: 4'b0000, rdy: 4'b0000});
        tbl.push_back('{v: 4'b0000, rdy: 4'b0000});
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v;
            settle(); model_check();
            chk($sformatf("tbl%0d_rdy", i), 64'(req_ready), 64'(tbl[i].rdy));
            advance();
        end

        // Reset one cycle after a grant: the in-flight request must never respond.
        reset_cycle();
        req_valid = 4'b0001;
        step();
        reset_cycle();
        req_valid = 4'b1111;
        settle(); model_check();
        chk("post_rst_ptr", 64'(req_ready), 64'h1);
        chk("drop_resp", 64'(resp_valid), 64'd0);
        advance();
        req_valid = '0;
        repeat (4) step();

        // Random traffic: operands held until granted, occasional withdrawal.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || prev_gnt[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    op_a[i]      = rand_dbl();
                    op_b[i]      = rand_dbl();
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end
        req_valid = '0;
        repeat (L + 3) step();
        chk("drain_queue_empty", 64'(pend.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
